// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_pkg
// Description : Shared types and constants for the programmable sequence
//               detector: controller state encoding, default widths and the
//               pattern-length clamp bounds.
// Config      : none (SEQ_DETECT_OVERLAP_EN is consumed by seq_match_core)
// Revision    : 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int c_pat_w_def = 8;
    localparam int c_win_w_def = 8;
    localparam int c_cnt_w_def = 8;

    // A one-bit "pattern" would match nearly every bit, so lengths are
    // clamped to at least two; the upper bound is the instance's PAT_W.
    localparam int c_len_min   = 2;

endpackage
`default_nettype wire

// File: rtl/seq_match_core.sv
`default_nettype none
// ============================================================================
// Module      : seq_match_core
// Description : Mealy matcher. Holds the received-bit history and a fill
//               count, compares the newest len bits against the pattern and
//               raises op in the same cycle as the final pattern bit.
// Ports       : clk, reset  - clock, synchronous active-high reset
//               clear       - restart history/fill (priority over shift)
//               shift       - accept ip this cycle (also qualifies op)
//               ip          - serial bit
//               pattern/len - latched pattern and clamped length
//               op          - combinational match output
// Config      : SEQ_DETECT_OVERLAP_EN - keep history after a match so
//               overlapping occurrences are found; otherwise history and fill
//               are cleared on the match edge.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = c_pat_w_def,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift,
    input  logic             ip,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             op
);

    logic [PAT_W-2:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] w_cand;
    logic [PAT_W-1:0] w_mask;
    logic             w_full;
    logic             w_hit;
    logic             w_restart;

    // Candidate word: stored history with the live bit as its LSB, so the
    // final pattern bit is compared without waiting for a register stage.
    assign w_cand = {r_hist, ip};

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(len));
        end
    end

    // len is always >= 2, so len-1 never wraps.
    assign w_full = (r_fill >= (len - LEN_W'(1)));
    assign w_hit  = (((w_cand ^ pattern) & w_mask) == '0);
    assign op     = shift & w_full & w_hit;

`ifdef SEQ_DETECT_OVERLAP_EN
    assign w_restart = clear;
`else
    assign w_restart = clear | op;
`endif

    always_ff @(posedge clk) begin
        if (reset || w_restart) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (shift) begin
            r_hist <= w_cand[PAT_W-2:0];
            if (r_fill != LEN_W'(PAT_W)) begin
                r_fill <= r_fill + LEN_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_ctrl
// Description : Run controller for the serial pattern matcher. Latches the
//               configuration on start, feeds qualified bits to the matcher
//               over a bounded window, counts matches and pulses done at the
//               end of a window.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               ip, ip_valid          - serial bit and its qualifier
//               start, stop           - begin/restart a run, abort a run
//               cfg_pattern/len/window- run configuration (window 0 = free run)
//               op                    - combinational Mealy match
//               state                 - IDLE=00, RUN=01, DONE=10
//               match_count           - saturating matches in current/last run
//               busy, done            - in RUN, one-cycle end-of-window pulse
// Config      : SEQ_DETECT_OVERLAP_EN (see seq_match_core)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = c_pat_w_def,
    parameter int WIN_W = c_win_w_def,
    parameter int CNT_W = c_cnt_w_def
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ip,
    input  logic                         ip_valid,
    input  logic                         start,
    input  logic                         stop,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic [WIN_W-1:0]             cfg_window,
    output logic                         op,
    output logic [1:0]                   state,
    output logic [CNT_W-1:0]             match_count,
    output logic                         busy,
    output logic                         done
);

    localparam int               c_len_w   = $clog2(PAT_W + 1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PAT_W-1:0]   r_pattern;
    logic [c_len_w-1:0] r_len;
    logic [c_len_w-1:0] w_len_clamped;
    logic [WIN_W-1:0]   r_window;
    logic [WIN_W-1:0]   r_remain;
    logic [CNT_W-1:0]   r_count;
    logic               w_accept;
    logic               w_load;
    logic               w_last;
    logic               w_op;

    assign w_len_clamped = (cfg_len < c_len_w'(c_len_min)) ? c_len_w'(c_len_min) :
                           (cfg_len > c_len_w'(PAT_W))     ? c_len_w'(PAT_W)     :
                                                             cfg_len;

    assign w_accept = (r_state == ST_RUN) && ip_valid;
    assign w_last   = w_accept && (r_window != '0) && (r_remain == WIN_W'(1));

    // Restart in RUN outranks end-of-window: a start on the last bit begins
    // a fresh run instead of finishing the old one.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pattern <= '0;
            r_len     <= c_len_w'(c_len_min);
            r_window  <= '0;
            r_remain  <= '0;
            r_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_pattern <= cfg_pattern;
                r_len     <= w_len_clamped;
                r_window  <= cfg_window;
                r_remain  <= cfg_window;
                r_count   <= '0;
            end else if (w_accept) begin
                if (r_window != '0) begin
                    r_remain <= r_remain - WIN_W'(1);
                end
                if (w_op && (r_count != c_cnt_max)) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    seq_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (c_len_w)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_load),
        .shift   (w_accept),
        .ip      (ip),
        .pattern (r_pattern),
        .len     (r_len),
        .op      (w_op)
    );

    assign op          = w_op;
    assign state       = r_state;
    assign match_count = r_count;
    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_ctrl
// Description : Directed, table-driven bench for seq_detect_ctrl with a few
//               hand-written multi-cycle sequences (overlap, saturation,
//               reset mid-run).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_detect_ctrl;

    localparam int PAT_W = 8;
    localparam int WIN_W = 8;
    localparam int CNT_W = 8;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             ip;
    logic             ip_valid;
    logic             start;
    logic             stop;
    logic [7:0]       cfg_pattern;
    logic [3:0]       cfg_len;
    logic [7:0]       cfg_window;
    logic             op;
    logic [1:0]       state;
    logic [7:0]       match_count;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    seq_detect_ctrl #(
        .PAT_W (PAT_W),
        .WIN_W (WIN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ip          (ip),
        .ip_valid    (ip_valid),
        .start       (start),
        .stop        (stop),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_window  (cfg_window),
        .op          (op),
        .state       (state),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        logic       st;
        logic       sp;
        logic       b;
        logic       v;
        logic [7:0] pat;
        logic [3:0] len;
        logic [7:0] win;
        logic       eop;
        logic [1:0] est;
        logic [7:0] ecnt;
        logic       edone;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] tp;
    logic [3:0] tl;
    logic [7:0] tw;
    int         checks = 0;
    int         errors = 0;
    int         exp_ovl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Append one cycle: inputs use the current tp/tl/tw configuration;
    // expectations are for the cycle before the following clock edge.
    task automatic add(input int st, input int sp, input int b, input int v,
                       input int eop, input int est, input int ecnt, input int edone);
        vec_t r;
        r.st    = 1'(st);
        r.sp    = 1'(sp);
        r.b     = 1'(b);
        r.v     = 1'(v);
        r.pat   = tp;
        r.len   = tl;
        r.win   = tw;
        r.eop   = 1'(eop);
        r.est   = 2'(est);
        r.ecnt  = 8'(ecnt);
        r.edone = 1'(edone);
        tbl.push_back(r);
    endtask

    // Configuration that a run must ignore when it is presented without start.
    task automatic junk_cfg();
        tp = 8'hFF;
        tl = 4'd3;
        tw = 8'd1;
    endtask

    task automatic cyc(input logic st, input logic sp, input logic b, input logic v);
        start       = st;
        stop        = sp;
        ip          = b;
        ip_valid    = v;
        cfg_pattern = tp;
        cfg_len     = tl;
        cfg_window  = tw;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; ip = 1'b0; ip_valid = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_window = '0;
        tp = '0; tl = '0; tw = '0;

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        chk("reset state", 32'(state), 32'(S_IDLE));
        chk("reset op", 32'(op), 32'd0);
        chk("reset count", 32'(match_count), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // ---------------- table construction ----------------
        // 1100, len 4, window 8, stream 11001100
        tp = 8'h0C; tl = 4'd4; tw = 8'd8;
        add(1,0,0,0, 0,S_IDLE,0,0);
        junk_cfg();
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,0,1, 0,S_RUN,0,0);
        add(0,0,0,1, 1,S_RUN,0,0);
        add(0,0,1,1, 0,S_RUN,1,0);
        add(0,0,1,1, 0,S_RUN,1,0);
        add(0,0,0,1, 0,S_RUN,1,0);
        add(0,0,0,1, 1,S_RUN,1,0);
        add(0,0,0,0, 0,S_DONE,2,1);
        add(0,0,0,0, 0,S_IDLE,2,0);

        // Free-running 1100 with ip_valid gaps, then stop keeps the count
        tp = 8'h0C; tl = 4'd4; tw = 8'd0;
        add(1,0,0,0, 0,S_IDLE,2,0);
        junk_cfg();
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,1,0, 0,S_RUN,0,0);
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,0,1, 0,S_RUN,0,0);
        add(0,0,0,0, 0,S_RUN,0,0);
        add(0,0,0,1, 1,S_RUN,0,0);
        add(0,0,0,1, 0,S_RUN,1,0);
        add(0,0,1,1, 0,S_RUN,1,0);
        add(0,0,1,1, 0,S_RUN,1,0);
        add(0,0,0,1, 0,S_RUN,1,0);
        add(0,0,1,0, 0,S_RUN,1,0);
        add(0,0,0,1, 1,S_RUN,1,0);
        add(0,1,0,0, 0,S_RUN,2,0);
        add(0,0,0,0, 0,S_IDLE,2,0);
        add(0,0,0,0, 0,S_IDLE,2,0);

        // start+stop together in RUN: stop wins, count retained
        tp = 8'h0C; tl = 4'd4; tw = 8'd0;
        add(1,0,0,0, 0,S_IDLE,2,0);
        junk_cfg();
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,0,1, 0,S_RUN,0,0);
        add(0,0,0,1, 1,S_RUN,0,0);
        add(1,1,0,0, 0,S_RUN,1,0);
        add(0,0,0,0, 0,S_IDLE,1,0);

        // start alone in RUN: restart with new pattern 01, len 2
        tp = 8'h0C; tl = 4'd4; tw = 8'd0;
        add(1,0,0,0, 0,S_IDLE,1,0);
        junk_cfg();
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,0,1, 0,S_RUN,0,0);
        add(0,0,0,1, 1,S_RUN,0,0);
        tp = 8'h01; tl = 4'd2; tw = 8'd0;
        add(1,0,0,0, 0,S_RUN,1,0);
        junk_cfg();
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,0,1, 0,S_RUN,0,0);
        add(0,0,1,1, 1,S_RUN,0,0);
        add(0,1,0,0, 0,S_RUN,1,0);
        add(0,0,0,0, 0,S_IDLE,1,0);

        // cfg_len 0 behaves as len 2 (pattern 10)
        tp = 8'h02; tl = 4'd0; tw = 8'd0;
        add(1,0,0,0, 0,S_IDLE,1,0);
        junk_cfg();
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,0,1, 1,S_RUN,0,0);
        add(0,0,0,1, 0,S_RUN,1,0);
        add(0,1,0,0, 0,S_RUN,1,0);
        add(0,0,0,0, 0,S_IDLE,1,0);

        // cfg_len 15 behaves as len 8 (pattern A5); the 7-bit tail must not match
        tp = 8'hA5; tl = 4'd15; tw = 8'd0;
        add(1,0,0,0, 0,S_IDLE,1,0);
        junk_cfg();
        add(0,0,0,1, 0,S_RUN,0,0);
        add(0,0,0,1, 0,S_RUN,0,0);
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,0,1, 0,S_RUN,0,0);
        add(0,0,0,1, 0,S_RUN,0,0);
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,0,1, 0,S_RUN,0,0);
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,0,1, 0,S_RUN,0,0);
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,0,1, 0,S_RUN,0,0);
        add(0,0,0,1, 0,S_RUN,0,0);
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,0,1, 0,S_RUN,0,0);
        add(0,0,1,1, 1,S_RUN,0,0);
        add(0,1,0,0, 0,S_RUN,1,0);
        add(0,0,0,0, 0,S_IDLE,1,0);

        // Match on the last window bit; start during DONE is ignored
        tp = 8'h02; tl = 4'd2; tw = 8'd2;
        add(1,0,0,0, 0,S_IDLE,1,0);
        junk_cfg();
        add(0,0,1,1, 0,S_RUN,0,0);
        add(0,0,0,1, 1,S_RUN,0,0);
        tp = 8'h02; tl = 4'd2; tw = 8'd2;
        add(1,0,0,0, 0,S_DONE,1,1);
        add(0,0,0,0, 0,S_IDLE,1,0);

        // ---------------- table application ----------------
        foreach (tbl[i]) begin
            start       = tbl[i].st;
            stop        = tbl[i].sp;
            ip          = tbl[i].b;
            ip_valid    = tbl[i].v;
            cfg_pattern = tbl[i].pat;
            cfg_len     = tbl[i].len;
            cfg_window  = tbl[i].win;
            #2;
            chk($sformatf("row%0d op", i), 32'(op), 32'(tbl[i].eop));
            chk($sformatf("row%0d state", i), 32'(state), 32'(tbl[i].est));
            chk($sformatf("row%0d count", i), 32'(match_count), 32'(tbl[i].ecnt));
            chk($sformatf("row%0d done", i), 32'(done), 32'(tbl[i].edone));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].est == 2'(S_RUN)));
            @(posedge clk);
            #1;
        end

        // ---------------- overlap: 101, len 3, window 5, stream 10101 ----------------
`ifdef SEQ_DETECT_OVERLAP_EN
        exp_ovl = 2;
`else
        exp_ovl = 1;
`endif
        tp = 8'h05; tl = 4'd3; tw = 8'd5;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        ip_valid = 1'b0;
        chk("overlap done", 32'(done), 32'd1);
        chk("overlap state", 32'(state), 32'(S_DONE));
        chk("overlap count", 32'(match_count), 32'(exp_ovl));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("overlap idle", 32'(state), 32'(S_IDLE));

        // ---------------- saturation: 260 matches of 10 ----------------
        tp = 8'h02; tl = 4'd2; tw = 8'd0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 260; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1);
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            if (k == 199) chk("sat count 200", 32'(match_count), 32'd200);
        end
        chk("sat count", 32'(match_count), 32'd255);
        chk("sat state", 32'(state), 32'(S_RUN));
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("sat stop state", 32'(state), 32'(S_IDLE));
        chk("sat stop count", 32'(match_count), 32'd255);

        // ---------------- reset mid-run ----------------
        tp = 8'h0C; tl = 4'd4; tw = 8'd8;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pre-reset count", 32'(match_count), 32'd1);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        chk("midrst state", 32'(state), 32'(S_IDLE));
        chk("midrst count", 32'(match_count), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst op", 32'(op), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst no done", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
